// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants and the fetch-stage update selector.
package fetch_unit_pkg;

  // Encoding of an all-zero instruction word, presented when fetch has nothing valid.
  localparam logic [31:0] NOP_INSTR = 32'b0;

  // Instruction size in bytes; the sequential PC step.
  localparam int unsigned INSTR_BYTES = 4;

  // Non-reset state update chosen for this cycle, highest priority first.
  typedef enum logic [1:0] {
    UPD_REDIRECT,
    UPD_STALL,
    UPD_ADVANCE
  } upd_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// Hold register for the fetched word: keeps the last returned instruction
// stable while the F/D register is stalled, and selects what InstrF shows.
module fetch_hold_buffer
  import fetch_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic         rsp_v,
  input  logic [W-1:0] rd_data,
  output logic         hold_v,
  output logic [W-1:0] instr,
  output logic         valid
);

  logic [W-1:0] hold_instr_q;
  logic         hold_v_q;

  // Valid flag: cleared on reset or whenever the stage moves; set on capture.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst)          hold_v_q <= 1'b0;
    else if (clear)   hold_v_q <= 1'b0;
    else if (capture) hold_v_q <= 1'b1;
  end

  // Data word: only loaded on capture.
  always_ff @(posedge clk) begin
    // NOTE: the data register is not reset; hold_v_q alone says whether it is meaningful.
    if (capture) hold_instr_q <= rd_data;
  end

  // Output select: held word first, then the live memory response, else NOP.
  always_comb begin
    // NOTE: default assigned first so no path through this block can infer a latch.
    instr = W'(NOP_INSTR);
    if (hold_v_q)   instr = hold_instr_q;
    else if (rsp_v) instr = rd_data;
  end

  assign hold_v = hold_v_q;
  assign valid  = hold_v_q | rsp_v;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous instruction
// memory and presents InstrF/PCF to the F/D register. Redirects from Execute
// override stalls; stalls park the returned word in fetch_hold_buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallF,
  input  logic         PCSrcE,
  input  logic [N-1:0] PCTargetE,
  output logic [N-1:0] ImemAddr,
  output logic         ImemRdEn,
  input  logic [N-1:0] ImemRdData,
  output logic [N-1:0] InstrF,
  output logic [N-1:0] PCF,
  output logic [N-1:0] PCPlus4F,
  output logic         ValidF
);

  localparam logic [N-1:0] PC_STEP = N'(INSTR_BYTES);

  logic [N-1:0] next_pc_q;   // address to issue next
  logic [N-1:0] fetch_pc_q;  // address whose data is in flight / presented
  logic         rsp_v_q;     // memory returns a live word this cycle
  logic         hold_v;
  logic [N-1:0] target_pc;
  logic         unused_target_bits;
  upd_e         upd;

  // Redirect targets are word aligned; the two low bits are ignored.
  assign target_pc          = {PCTargetE[N-1:2], 2'b00};
  assign unused_target_bits = ^PCTargetE[1:0];

  // Pick this cycle's update: redirect beats stall beats advance.
  always_comb begin
    upd = UPD_ADVANCE;
    if (PCSrcE)      upd = UPD_REDIRECT;
    else if (StallF) upd = UPD_STALL;
  end

  // PC and response-valid state; reset discards everything including a pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pc_q  <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rsp_v_q    <= 1'b0;
    end else begin
      case (upd)
        UPD_REDIRECT: begin
          fetch_pc_q <= target_pc;
          next_pc_q  <= target_pc + PC_STEP;
          rsp_v_q    <= 1'b1;
        end
        UPD_STALL: begin
          rsp_v_q <= 1'b0;
        end
        default: begin
          fetch_pc_q <= next_pc_q;
          next_pc_q  <= next_pc_q + PC_STEP;
          rsp_v_q    <= 1'b1;
        end
      endcase
    end
  end

  // Memory request: a redirect issues its target immediately, even when stalled.
  assign ImemAddr = PCSrcE ? target_pc : next_pc_q;
  assign ImemRdEn = PCSrcE | ~StallF;

  assign PCF      = fetch_pc_q;
  assign PCPlus4F = fetch_pc_q + PC_STEP;

  fetch_hold_buffer #(.W(N)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .capture ((upd == UPD_STALL) & rsp_v_q & ~hold_v),
    .clear   (upd != UPD_STALL),
    .rsp_v   (rsp_v_q),
    .rd_data (ImemRdData),
    .hold_v  (hold_v),
    .instr   (InstrF),
    .valid   (ValidF)
  );

endmodule
